ram_port_arbiter: RTL

Round-robin arbiter that shares the single RAM port among `NREQ` requesters (instruction and data ports of each CPU, or cache-side sequencers). It grants one requester at a time and holds the grant until RAM reports `ACCESS`. A requester can lock the port for a multi-word burst, capped at `MAXBURST` consecutive accesses. It sits between the requesters and the RAM model and uses the `ramstate` encoding from `cpu_types_pkg`: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

---
 rtl/ram_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin owner of the single RAM port.
// One requester is granted at a time. The grant is held until RAM answers
// ACCESS or ERROR, or until the owner drops its request. A locked owner may
// keep the port for up to MAXBURST back-to-back accesses. Every grant ends
// with a one-cycle RELEASE bubble.

// Per-requester response slice: forwards RAM status to the owner only.
module ram_port_arbiter_lane (
  input  logic        sel,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        rwait,
  output logic [31:0] rload,
  output logic        rerr
);
  // Only the selected lane sees completion, data and error; others idle.
  always_comb begin
    rwait = 1'b1;
    rload = '0;
    rerr  = 1'b0;
    if (sel) begin
      rwait = (ramstate != 2'd2);
      rload = ramload;
      rerr  = (ramstate == 2'd3);
    end
  end
endmodule

module ram_port_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REN,
  input  logic [NREQ-1:0]       WEN,
  input  logic [NREQ-1:0][31:0] addr,
  input  logic [NREQ-1:0][31:0] store,
  input  logic [NREQ-1:0]       lock,
  output logic [NREQ-1:0]       rwait,
  output logic [NREQ-1:0][31:0] rload,
  output logic [NREQ-1:0]       rerr,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate,
  output logic [2:0]            owner
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state;
  logic [2:0]      rr_ptr;
  logic [3:0]      burst_cnt;

  logic [NREQ-1:0] act;
  logic [IW-1:0]   oidx;
  logic            granted;
  logic            own_act;
  logic            is_access;
  logic            is_error;
  logic [2:0]      next_ptr;
  logic            pick_found;
  logic [2:0]      pick_idx;
  logic [3:0]      sum;
  logic [NREQ-1:0] sel;

  assign act       = REN | WEN;
  assign oidx      = owner[IW-1:0];
  assign granted   = (state == GRANT);
  assign own_act   = act[oidx];
  assign is_access = (ramstate == RS_ACCESS);
  assign is_error  = (ramstate == RS_ERROR);
  assign next_ptr  = (owner == 3'(NREQ-1)) ? 3'd0 : owner + 3'd1;

  // First active requester at or after rr_ptr; scanning downward lets the
  // nearest candidate overwrite farther ones.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + 4'(k);
      if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
      if (act[sum[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = sum[2:0];
      end
    end
  end

  // RAM side follows the owner combinationally; ERROR drops the enables.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (granted) begin
      ramaddr  = addr[oidx];
      ramstore = store[oidx];
      ramWEN   = WEN[oidx] & ~is_error;
      ramREN   = REN[oidx] & ~WEN[oidx] & ~is_error;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign sel[gi] = granted && (oidx == IW'(gi));
      ram_port_arbiter_lane u_lane (
        .sel      (sel[gi]),
        .ramstate (ramstate),
        .ramload  (ramload),
        .rwait    (rwait[gi]),
        .rload    (rload[gi]),
        .rerr     (rerr[gi])
      );
    end
  endgenerate

  // Grant FSM: pick in IDLE, hold/burst in GRANT, one bubble in RELEASE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner     <= pick_idx;
            burst_cnt <= 4'd1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!own_act) begin
            // withdrawn request: no completion, fairness pointer untouched
            state <= RELEASE;
          end else if (is_access) begin
            if (lock[oidx] && (burst_cnt < 4'(MAXBURST))) begin
              burst_cnt <= burst_cnt + 4'd1;
            end else begin
              state  <= RELEASE;
              rr_ptr <= next_ptr;
            end
          end else if (is_error) begin
            state  <= RELEASE;
            rr_ptr <= next_ptr;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
